// File: rtl/cmd_arb_pkg.sv
// Shared command codes, default timing constants and FSM state types for cmd_arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmd_arb_pkg;

    typedef enum logic [2:0] {
        CMD_STOP  = 3'd0,
        CMD_FWD   = 3'd1,
        CMD_BACK  = 3'd2,
        CMD_LEFT  = 3'd3,
        CMD_RIGHT = 3'd4,
        CMD_SPIN  = 3'd5
    } cmd_t;

    // 0.25 s ownership hold and 1 s silence watchdog at 50 MHz
    localparam int HOLD_CYCLES_DEFAULT    = 12_500_000;
    localparam int TIMEOUT_CYCLES_DEFAULT = 50_000_000;

    typedef enum logic {IDLE, OWNED} own_state_t;
    typedef enum logic {EMPTY, FULL} out_state_t;

    // Bits needed to hold 0..max, never less than one
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/arb_down_counter.sv
// Loadable saturating down-counter with a zero flag.
// Latency: load/tick take effect on the next clk edge; zero is combinational from the count.
// Backpressure: none; tick at zero holds the count at zero.
//
// Ports: clk, reset (sync, active-high), load (count <= MAX, wins over tick),
//        tick (decrement unless already zero), zero (count == 0).
module arb_down_counter
    import cmd_arb_pkg::*;
#(
    parameter int MAX        = 8,
    parameter bit RESET_FULL = 1'b0   // reset to MAX instead of 0
)(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic zero
);

    localparam int             W     = cnt_width(MAX);
    localparam logic [W-1:0]   MAX_V = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= RESET_FULL ? MAX_V : '0;
        end else if (load) begin
            cnt <= MAX_V;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cmd_arbiter.sv
// Fixed-priority command arbiter with ownership hold, per-source mask, last-wins coalescing and silence watchdog.
// Latency: accept at cycle T shows on out_cmd/out_valid and owner/owner_valid at T+1.
// Backpressure: one output slot; a new command while the slot is stalled overwrites it and bumps dropped_count.
//
// Ports: clk, reset (sync, active-high); src_cmd/src_valid/src_enable per source (index 0 = highest priority);
//        out_cmd/out_valid/out_ready towards the translator; owner/owner_valid; timeout_stop; dropped_count.
module cmd_arbiter
    import cmd_arb_pkg::*;
#(
    parameter int               N_SRC          = 4,
    parameter int               CMD_W          = 3,
    parameter int               HOLD_CYCLES    = HOLD_CYCLES_DEFAULT,
    parameter int               TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter logic [CMD_W-1:0] STOP_CMD       = CMD_W'(CMD_STOP),
    parameter int               SRC_W          = (N_SRC > 1) ? $clog2(N_SRC) : 1
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SRC*CMD_W-1:0] src_cmd,
    input  logic [N_SRC-1:0]       src_valid,
    input  logic [N_SRC-1:0]       src_enable,
    output logic [CMD_W-1:0]       out_cmd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SRC_W-1:0]       owner,
    output logic                   owner_valid,
    output logic                   timeout_stop,
    output logic [7:0]             dropped_count
);

    own_state_t       own_state, own_next;
    out_state_t       out_state, out_next;
    logic             accept;
    logic [SRC_W-1:0] sel;
    logic [CMD_W-1:0] sel_cmd;
    logic [CMD_W-1:0] emit_cmd;
    logic [CMD_W-1:0] ref_cmd;
    logic [CMD_W-1:0] last_sent;
    logic             emit;
    logic             xfer;
    logic             hold_zero;
    logic             wd_zero;
    logic             wd_fire;

    // ---------------- source selection ----------------
    // Scan from the lowest priority upwards so the lowest eligible index is the last write.
    always_comb begin
        accept  = 1'b0;
        sel     = '0;
        sel_cmd = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_valid[i] && src_enable[i] && (!owner_valid || (SRC_W'(i) <= owner))) begin
                accept  = 1'b1;
                sel     = SRC_W'(i);
                sel_cmd = src_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    // ---------------- hold and watchdog counters ----------------
    arb_down_counter #(
        .MAX        (HOLD_CYCLES),
        .RESET_FULL (1'b0)
    ) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .tick  (owner_valid),
        .zero  (hold_zero)
    );

    // Counts down the remaining silence budget: full = no idle cycles seen yet,
    // zero = TIMEOUT_CYCLES idle cycles since the last accept (or reset).
    arb_down_counter #(
        .MAX        (TIMEOUT_CYCLES),
        .RESET_FULL (1'b1)
    ) u_wd_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .tick  (!accept),
        .zero  (wd_zero)
    );

    // The counter saturates at zero; timeout_stop keeps it from firing again until an accept.
    assign wd_fire = wd_zero && !accept && !timeout_stop;

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_stop <= 1'b0;
        end else if (accept) begin
            timeout_stop <= 1'b0;
        end else if (wd_fire) begin
            timeout_stop <= 1'b1;
        end
    end

    // ---------------- ownership FSM ----------------
    assign owner_valid = (own_state == OWNED);

    always_ff @(posedge clk) begin
        if (reset) begin
            own_state <= IDLE;
            owner     <= '0;
        end else begin
            own_state <= own_next;
            if (accept) begin
                owner <= sel;
            end
        end
    end

    always_comb begin
        own_next = own_state;
        case (own_state)
            IDLE: begin
                if (accept) begin
                    own_next = OWNED;
                end
            end
            OWNED: begin
                if (accept) begin
                    own_next = OWNED;
                end else if (wd_fire || hold_zero || !src_enable[owner]) begin
                    own_next = IDLE;
                end
            end
            default: own_next = IDLE;
        endcase
    end

    // ---------------- output slot FSM ----------------
    assign out_valid = (out_state == FULL);
    assign xfer      = out_valid && out_ready;

    // Suppress repeats of whatever the translator already has or is about to get.
    assign ref_cmd   = out_valid ? out_cmd : last_sent;
    assign emit_cmd  = accept ? sel_cmd : STOP_CMD;
    assign emit      = (accept || wd_fire) && (emit_cmd != ref_cmd);

    always_comb begin
        out_next = out_state;
        case (out_state)
            EMPTY: begin
                if (emit) begin
                    out_next = FULL;
                end
            end
            FULL: begin
                // Transfer plus a fresh emit keeps the slot full with the new command.
                if (xfer && !emit) begin
                    out_next = EMPTY;
                end
            end
            default: out_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_state     <= EMPTY;
            out_cmd       <= STOP_CMD;
            last_sent     <= STOP_CMD;
            dropped_count <= 8'd0;
        end else begin
            out_state <= out_next;
            if (xfer) begin
                last_sent <= out_cmd;
            end
            if (emit) begin
                out_cmd <= emit_cmd;
            end
            // Only a stalled slot loses its command; saturate rather than wrap.
            if (emit && out_valid && !xfer && (dropped_count != 8'hFF)) begin
                dropped_count <= dropped_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Self-checking bench for cmd_arbiter: directed scenarios, a drop-saturation run and a randomized phase.
// Latency: reference model predicts outputs one clock after the inputs are sampled.
// Backpressure: out_ready is driven directly, fixed in directed steps and random in the random phase.
module tb_cmd_arbiter;
    import cmd_arb_pkg::*;

    localparam int N    = 4;
    localparam int W    = 3;
    localparam int HOLD = 8;
    localparam int TO   = 20;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] src_cmd;
    logic [N-1:0]   src_valid;
    logic [N-1:0]   src_enable;
    logic [W-1:0]   out_cmd;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     owner;
    logic           owner_valid;
    logic           timeout_stop;
    logic [7:0]     dropped_count;

    always #5 clk = ~clk;

    cmd_arbiter #(
        .N_SRC          (N),
        .CMD_W          (W),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .src_cmd       (src_cmd),
        .src_valid     (src_valid),
        .src_enable    (src_enable),
        .out_cmd       (out_cmd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .owner         (owner),
        .owner_valid   (owner_valid),
        .timeout_stop  (timeout_stop),
        .dropped_count (dropped_count)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: what the DUT outputs should read after the latest edge.
    int cyc     = 0;
    bit m_ov    = 0;   // a command is waiting for the translator
    int m_oc    = 0;   // the waiting (or most recently loaded) command
    int m_ls    = 0;   // last command handed to the translator
    int m_drop  = 0;
    int m_own   = 0;
    bit m_owned = 0;
    bit m_ts    = 0;
    int acc_cyc = 0;   // edge index of the owner's last accept
    int sil_ref = 0;   // edge index of the last accept or reset

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    endtask

    task automatic model_step();
        int sel;
        bit acc, fire, emit, xfer;
        int ecmd, refc;
        if (reset) begin
            m_ov = 0; m_oc = 0; m_ls = 0; m_drop = 0;
            m_own = 0; m_owned = 0; m_ts = 0;
            sil_ref = cyc;
        end else begin
            sel = -1;
            for (int i = N - 1; i >= 0; i--)
                if (src_valid[i] && src_enable[i] && (!m_owned || i <= m_own)) sel = i;
            acc  = (sel >= 0);
            // Silence of exactly TO idle cycles since the last accept/reset
            fire = !acc && (cyc == sil_ref + TO + 1);
            ecmd = 0;
            if (acc) ecmd = int'(src_cmd[sel*W +: W]);
            refc = m_ov ? m_oc : m_ls;
            emit = (acc || fire) && (ecmd != refc);
            xfer = m_ov && out_ready;
            if (xfer) m_ls = m_oc;
            if (emit) begin
                if (m_ov && !xfer && m_drop < 255) m_drop++;
                m_oc = ecmd;
                m_ov = 1;
            end else if (xfer) begin
                m_ov = 0;
            end
            if (acc) begin
                m_owned = 1; m_own = sel; acc_cyc = cyc; sil_ref = cyc; m_ts = 0;
            end else if (fire) begin
                m_owned = 0; m_ts = 1;
            end else if (m_owned && ((cyc >= acc_cyc + HOLD + 1) || !src_enable[m_own])) begin
                m_owned = 0;
            end
        end
    endtask

    // One clock: model consumes the sampled inputs, outputs are compared 1 ns after the edge,
    // then the one-cycle strobes are withdrawn.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check("out_valid",     out_valid,     m_ov);
        check("out_cmd",       out_cmd,       m_oc);
        check("owner_valid",   owner_valid,   m_owned);
        check("owner",         owner,         m_own);
        check("timeout_stop",  timeout_stop,  m_ts);
        check("dropped_count", dropped_count, m_drop);
        src_valid = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic strobe(input int i, input int c);
        logic [W-1:0] cw;
        cw = W'(c);
        src_valid[i]         = 1'b1;
        src_cmd[i*W +: W]    = cw;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        src_cmd    = '0;
        src_valid  = '0;
        src_enable = '1;
        out_ready  = 1'b1;

        // Reset state
        idle(2);
        check("rst_out_valid",    out_valid,     0);
        check("rst_out_cmd",      out_cmd,       CMD_STOP);
        check("rst_owner_valid",  owner_valid,   0);
        check("rst_timeout_stop", timeout_stop,  0);
        check("rst_dropped",      dropped_count, 0);
        reset = 1'b0;

        // 1: single command, one-cycle latency, immediate transfer
        strobe(2, CMD_FWD);
        check("s1_out_valid", out_valid, 1);
        check("s1_out_cmd",   out_cmd,   CMD_FWD);
        check("s1_owner",     owner,     2);
        idle(1);
        check("s1_drained",   out_valid, 0);

        // 2: lower priority ignored during hold, accepted after expiry
        idle(1);
        strobe(3, CMD_LEFT);
        check("s2_ignored_owner", owner,     2);
        check("s2_ignored_ov",    out_valid, 0);
        idle(6);
        strobe(3, CMD_LEFT);
        check("s2_owner", owner,   3);
        check("s2_cmd",   out_cmd, CMD_LEFT);

        // 3: preemption, then a same-cycle tie
        strobe(0, CMD_STOP);
        check("s3_preempt_owner", owner,     0);
        check("s3_preempt_cmd",   out_cmd,   CMD_STOP);
        check("s3_preempt_ov",    out_valid, 1);
        idle(10);
        src_valid[1] = 1'b1;
        src_cmd[1*W +: W] = W'(CMD_FWD);
        strobe(0, CMD_RIGHT);
        check("s3_tie_owner", owner,   0);
        check("s3_tie_cmd",   out_cmd, CMD_RIGHT);

        // 4: coalescing under back-pressure
        idle(10);
        out_ready = 1'b0;
        strobe(1, CMD_FWD);
        strobe(1, CMD_BACK);
        strobe(1, CMD_RIGHT);
        check("s4_cmd",     out_cmd,       CMD_RIGHT);
        check("s4_dropped", dropped_count, 2);
        out_ready = 1'b1;
        idle(1);
        check("s4_xfer", out_valid, 0);
        strobe(1, CMD_RIGHT);
        check("s4_repeat_suppressed", out_valid, 0);

        // 5: watchdog
        strobe(1, CMD_FWD);
        idle(20);
        check("s5_not_yet", timeout_stop, 0);
        idle(1);
        check("s5_tstop",   timeout_stop, 1);
        check("s5_stop_ov", out_valid,    1);
        check("s5_stop",    out_cmd,      CMD_STOP);
        check("s5_no_own",  owner_valid,  0);
        idle(25);
        check("s5_once",    out_valid,    0);
        strobe(2, CMD_BACK);
        check("s5_clear",   timeout_stop, 0);
        idle(1);

        // 6: reset aborts pending output and forgets last_sent
        out_ready = 1'b0;
        strobe(2, CMD_LEFT);
        reset = 1'b1;
        tick();
        check("s6_rst_ov",  out_valid,   0);
        check("s6_rst_own", owner_valid, 0);
        check("s6_rst_cmd", out_cmd,     CMD_STOP);
        reset = 1'b0;
        strobe(2, CMD_BACK);
        check("s6_reemit_ov",  out_valid, 1);
        check("s6_reemit_cmd", out_cmd,   CMD_BACK);
        out_ready = 1'b1;
        idle(1);

        // Drop counter saturation
        out_ready = 1'b0;
        for (int k = 0; k < 260; k++) strobe(0, (k % 2 == 0) ? CMD_FWD : CMD_LEFT);
        check("sat_dropped", dropped_count, 255);
        out_ready = 1'b1;
        idle(2);

        // Randomized phase with quiet windows so the watchdog gets exercised
        for (int k = 0; k < 900; k++) begin
            reset      = ($urandom_range(0, 199) == 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                src_enable[i] = ($urandom_range(0, 9) != 0);
                src_valid[i]  = ((k / 50) % 3 != 2) && ($urandom_range(0, 3) == 0);
                src_cmd[i*W +: W] = W'($urandom_range(0, 7));
            end
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
